motor_drive_shaper: RTL and testbench

//  Sits between the steering/PID logic and pwm_gen for one motor. Takes a signed

---
 rtl/motor_drive_shaper_if.sv | 13 +
 rtl/motor_drive_shaper.sv | 160 ++++++++++++++++
 tb/tb_motor_drive_shaper.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_drive_shaper_if.sv
// Command/drive bundle between the steering logic and one motor's duty shaper.
interface motor_drive_shaper_if;
  logic signed [10:0] cmd;
  logic               cmd_vld;
  logic               en;
  logic        [9:0]  duty;
  logic               fwd;
  logic               rev;
  logic               busy;

  modport master (output cmd, cmd_vld, en, input duty, fwd, rev, busy);
  modport slave  (input cmd, cmd_vld, en, output duty, fwd, rev, busy);
endinterface

// File: rtl/motor_drive_shaper.sv
// Slew-limits a signed drive command into duty/direction for one H-bridge,
// updating only at PWM period boundaries and braking through dead time on reversal.
module motor_drive_shaper #(
  parameter int STEP     = 32,
  parameter int DEAD_PER = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  motor_drive_shaper_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] RAMP_DN = 2'd2;
  localparam logic [1:0] DEAD    = 2'd3;

  localparam logic [9:0] STEP_V = 10'(STEP);
  localparam logic [3:0] DEAD_V = 4'(DEAD_PER);

  // -1024 has no positive counterpart in 11 bits, so clamp it to -1023.
  function automatic logic signed [10:0] sat_cmd(input logic signed [10:0] c);
    if (c == 11'sh400) return 11'sh401;
    return c;
  endfunction

  function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] t);
    logic [9:0] d;
    d = '0;
    if (cur < t) begin
      d = t - cur;
      return cur + ((d < STEP_V) ? d : STEP_V);
    end
    d = cur - t;
    return cur - ((d < STEP_V) ? d : STEP_V);
  endfunction

  logic        [9:0]  per_cnt;
  logic               tick;
  logic signed [10:0] tgt;
  logic signed [10:0] tgt_neg;
  logic        [9:0]  mag;
  logic               sgn;

  logic [1:0] state, state_d;
  logic [9:0] duty, duty_d;
  logic       fwd, fwd_d;
  logic       rev, rev_d;
  logic       dir, dir_d;
  logic [3:0] dead_cnt, dead_d;
  logic [9:0] duty_up, duty_dn, duty_first;

  assign tick    = (per_cnt == 10'd1023);
  assign tgt_neg = -tgt;
  assign sgn     = tgt[10];
  assign mag     = sgn ? tgt_neg[9:0] : tgt[9:0];

  // Period timer and command capture run every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      tgt     <= '0;
    end else begin
      per_cnt <= per_cnt + 10'd1;
      if (bus.cmd_vld) tgt <= sat_cmd(bus.cmd);
    end
  end

  always_comb begin
    state_d    = state;
    duty_d     = duty;
    fwd_d      = fwd;
    rev_d      = rev;
    dir_d      = dir;
    dead_d     = dead_cnt;
    duty_up    = slew(duty, mag);
    duty_dn    = slew(duty, 10'd0);
    duty_first = slew(10'd0, mag);
    case (state)
      IDLE: begin
        duty_d = '0;
        fwd_d  = 1'b0;
        rev_d  = 1'b0;
        if (bus.en && mag != 10'd0) begin
          state_d = RUN;
          dir_d   = sgn;
          duty_d  = duty_first;
          fwd_d   = ~sgn;
          rev_d   = sgn;
        end
      end
      RUN: begin
        fwd_d = ~dir;
        rev_d = dir;
        if (!bus.en || (mag != 10'd0 && sgn != dir)) begin
          state_d = RAMP_DN;
          duty_d  = duty_dn;
        end else begin
          duty_d = duty_up;
          if (mag == 10'd0 && duty_up == 10'd0) begin
            state_d = IDLE;
            fwd_d   = 1'b0;
            rev_d   = 1'b0;
          end
        end
      end
      RAMP_DN: begin
        duty_d = duty_dn;
        if (duty_dn == 10'd0) begin
          state_d = DEAD;
          dead_d  = DEAD_V;
          fwd_d   = 1'b0;
          rev_d   = 1'b0;
        end
      end
      DEAD: begin
        duty_d = '0;
        fwd_d  = 1'b0;
        rev_d  = 1'b0;
        dead_d = dead_cnt - 4'd1;
        if (dead_cnt == 4'd1) begin
          if (bus.en && mag != 10'd0) begin
            state_d = RUN;
            dir_d   = sgn;
            duty_d  = duty_first;
            fwd_d   = ~sgn;
            rev_d   = sgn;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drive state commits only on the period tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty     <= '0;
      fwd      <= 1'b0;
      rev      <= 1'b0;
      dir      <= 1'b0;
      dead_cnt <= '0;
    end else if (tick) begin
      state    <= state_d;
      duty     <= duty_d;
      fwd      <= fwd_d;
      rev      <= rev_d;
      dir      <= dir_d;
      dead_cnt <= dead_d;
    end
  end

  assign bus.duty = duty;
  assign bus.fwd  = fwd;
  assign bus.rev  = rev;
  assign bus.busy = (state == RAMP_DN) || (state == DEAD);

endmodule

// File: tb/tb_motor_drive_shaper.sv
// Directed bench for motor_drive_shaper: ramp, reversal, stop, saturation, tick capture, reset.
module tb_motor_drive_shaper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  motor_drive_shaper_if bus();

  motor_drive_shaper #(.STEP(32), .DEAD_PER(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Bench copy of the period counter, reset together with the DUT
  logic [9:0] tb_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 10'd1;
  end

  task automatic next_tick();
    while (tb_cnt != 10'd1023) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd(input logic signed [10:0] v);
    @(negedge clk);
    bus.cmd     = v;
    bus.cmd_vld = 1'b1;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.cmd = '0; bus.cmd_vld = 1'b0; bus.en = 1'b0;
    rst_n = 1'b0;
    #23;
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_hold: duty=%0d fwd=%b rev=%b busy=%b, required all 0",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_tick();
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_idle_tick: duty=%0d fwd=%b rev=%b busy=%b, required all 0",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
  endtask

  task automatic test_ramp_up();
    int ed[4] = '{32, 64, 96, 100};
    bus.en = 1'b1;
    pulse_cmd(11'sd100);
    for (int i = 0; i < 4; i++) begin
      next_tick();
      n_chk++;
      if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== {10'(ed[i]), 3'b100}) begin
        n_fail++;
        $display("FAIL ramp_up tick %0d: duty=%0d fwd=%b rev=%b busy=%b, required duty=%0d fwd=1 rev=0 busy=0",
                 i + 1, bus.duty, bus.fwd, bus.rev, bus.busy, ed[i]);
      end
    end
  endtask

  task automatic test_reverse();
    int ed[7] = '{68, 36, 4, 0, 0, 32, 50};
    int ef[7] = '{1, 1, 1, 0, 0, 0, 0};
    int er[7] = '{0, 0, 0, 0, 0, 1, 1};
    int eb[7] = '{1, 1, 1, 1, 1, 0, 0};
    pulse_cmd(-11'sd50);
    for (int i = 0; i < 7; i++) begin
      next_tick();
      n_chk++;
      if ({bus.duty, bus.fwd, bus.rev, bus.busy} !==
          {10'(ed[i]), 1'(ef[i]), 1'(er[i]), 1'(eb[i])}) begin
        n_fail++;
        $display("FAIL reverse tick %0d: duty=%0d fwd=%b rev=%b busy=%b, required duty=%0d fwd=%0d rev=%0d busy=%0d",
                 i + 1, bus.duty, bus.fwd, bus.rev, bus.busy, ed[i], ef[i], er[i], eb[i]);
      end
      n_chk++;
      if ((bus.fwd & bus.rev) !== 1'b0) begin
        n_fail++;
        $display("FAIL reverse_overlap tick %0d: fwd&rev=%b, required 0", i + 1, bus.fwd & bus.rev);
      end
    end
  endtask

  task automatic test_en_off();
    int ed[6] = '{68, 36, 4, 0, 0, 0};
    int ef[6] = '{1, 1, 1, 0, 0, 0};
    int eb[6] = '{1, 1, 1, 1, 1, 0};
    pulse_cmd(11'sd100);
    for (int i = 0; i < 7; i++) next_tick();
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== {10'd100, 3'b100}) begin
      n_fail++;
      $display("FAIL en_off_setup: duty=%0d fwd=%b rev=%b busy=%b, required duty=100 fwd=1 rev=0 busy=0",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_tick();
      n_chk++;
      if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== {10'(ed[i]), 1'(ef[i]), 1'b0, 1'(eb[i])}) begin
        n_fail++;
        $display("FAIL en_off tick %0d: duty=%0d fwd=%b rev=%b busy=%b, required duty=%0d fwd=%0d rev=0 busy=%0d",
                 i + 1, bus.duty, bus.fwd, bus.rev, bus.busy, ed[i], ef[i], eb[i]);
      end
    end
    next_tick();
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL en_off_idle: duty=%0d fwd=%b rev=%b busy=%b, required all 0",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
    bus.en = 1'b1;
    next_tick();
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== {10'd32, 3'b100}) begin
      n_fail++;
      $display("FAIL en_restart tick 1: duty=%0d fwd=%b rev=%b busy=%b, required duty=32 fwd=1 rev=0 busy=0",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
    next_tick();
    n_chk++;
    if (bus.duty !== 10'd64) begin
      n_fail++;
      $display("FAIL en_restart tick 2: duty=%0d, required 64", bus.duty);
    end
  endtask

  task automatic test_cmd_on_tick();
    pulse_cmd(11'sd40);
    next_tick();
    n_chk++;
    if (bus.duty !== 10'd40) begin
      n_fail++;
      $display("FAIL tick_cmd_settle: duty=%0d, required 40", bus.duty);
    end
    while (tb_cnt != 10'd1023) @(negedge clk);
    bus.cmd     = 11'sd200;
    bus.cmd_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_vld = 1'b0;
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev} !== {10'd40, 2'b10}) begin
      n_fail++;
      $display("FAIL tick_cmd_old_target: duty=%0d fwd=%b rev=%b, required duty=40 fwd=1 rev=0",
               bus.duty, bus.fwd, bus.rev);
    end
    next_tick();
    n_chk++;
    if (bus.duty !== 10'd72) begin
      n_fail++;
      $display("FAIL tick_cmd_new_target 1: duty=%0d, required 72", bus.duty);
    end
    next_tick();
    n_chk++;
    if (bus.duty !== 10'd104) begin
      n_fail++;
      $display("FAIL tick_cmd_new_target 2: duty=%0d, required 104", bus.duty);
    end
  endtask

  task automatic test_saturate();
    int exp_d;
    do_reset();
    pulse_cmd(-11'sd1024);
    for (int k = 1; k <= 34; k++) begin
      next_tick();
      exp_d = (32 * k > 1023) ? 1023 : 32 * k;
      n_chk++;
      if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== {10'(exp_d), 3'b010}) begin
        n_fail++;
        $display("FAIL saturate tick %0d: duty=%0d fwd=%b rev=%b busy=%b, required duty=%0d fwd=0 rev=1 busy=0",
                 k, bus.duty, bus.fwd, bus.rev, bus.busy, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_cmd(11'sd100);
    for (int i = 0; i < 4; i++) next_tick();
    pulse_cmd(-11'sd50);
    next_tick();
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== {10'd68, 3'b101}) begin
      n_fail++;
      $display("FAIL reset_mid_setup: duty=%0d fwd=%b rev=%b busy=%b, required duty=68 fwd=1 rev=0 busy=1",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
    while (tb_cnt != 10'd300) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: duty=%0d fwd=%b rev=%b busy=%b, required all 0",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
    n_chk++;
    if (dut.per_cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_per_cnt: per_cnt=%0d, required 0", dut.per_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_tick();
    n_chk++;
    if ({bus.duty, bus.fwd, bus.rev, bus.busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: duty=%0d fwd=%b rev=%b busy=%b, required all 0",
               bus.duty, bus.fwd, bus.rev, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reverse();
    test_en_off();
    test_cmd_on_tick();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion before limit");
    $fatal(1, "watchdog expired");
  end

endmodule
